// File: rtl/sid_mix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sid_mix_pkg
// Description : Shared types, widths and helpers for the SID three-voice
//               mixer (state encoding, datapath widths, saturation limits,
//               unsigned-to-signed sample conversion).
// Revision    : 1.0 - initial release
// ============================================================================
package sid_mix_pkg;

    localparam int VOICE_W  = 12;
    localparam int SAMPLE_W = 13;
    localparam int ACC_W    = 16;
    localparam int PROD_W   = 21;

    localparam logic [VOICE_W-1:0]      MIDPOINT = 12'h800;
    localparam logic signed [ACC_W-1:0] SAT_MAX  = 16'sh7FFF;
    localparam logic signed [ACC_W-1:0] SAT_MIN  = 16'sh8000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_V1   = 3'd1,
        ST_V2   = 3'd2,
        ST_V3   = 3'd3,
        ST_EXT  = 3'd4,
        ST_VOL  = 3'd5
    } mix_state_t;

    // Voice outputs idle at mid-scale; re-centre them on zero.
    function automatic logic signed [SAMPLE_W-1:0] to_sample(input logic [VOICE_W-1:0] v);
        return $signed({1'b0, v} - {1'b0, MIDPOINT});
    endfunction

endpackage
`default_nettype wire

// File: rtl/sid_mix_sat.sv
`default_nettype none
// ============================================================================
// Module      : sid_mix_sat
// Description : Combinational arithmetic shift-right-by-4 (floor) followed by
//               saturation from PROD_W to ACC_W bits.
// Ports       : i_prod   - signed PROD_W-bit product
//               o_sample - signed ACC_W-bit clamped result
// Revision    : 1.0 - initial release
// ============================================================================
module sid_mix_sat
    import sid_mix_pkg::*;
(
    input  logic signed [PROD_W-1:0] i_prod,
    output logic signed [ACC_W-1:0]  o_sample
);

    localparam logic signed [PROD_W-1:0] c_max = PROD_W'(SAT_MAX);
    localparam logic signed [PROD_W-1:0] c_min = PROD_W'(SAT_MIN);

    logic signed [PROD_W-1:0] w_shifted;

    assign w_shifted = i_prod >>> 4;

    always_comb begin
        o_sample = w_shifted[ACC_W-1:0];
        if (w_shifted > c_max) begin
            o_sample = SAT_MAX;
        end else if (w_shifted < c_min) begin
            o_sample = SAT_MIN;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sid_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module      : sid_voice_mixer
// Description : Sequential three-voice (plus optional EXT IN) mixer. On each
//               ce_1m strobe the inputs are snapshotted, DC-removed and
//               accumulated one source per clock through a single shared
//               adder into either the filter-input or the direct sum. The
//               direct sum plus the previous frame's filter output is then
//               volume-scaled and saturated to a 16-bit audio sample.
// Config      : SID_EXT_IN_EN - when defined, ext_in is mixed as a fourth
//               source (routed by res_filt[3]) and latency is 6 clocks;
//               otherwise ext_in is ignored and latency is 5 clocks.
// Ports       : clock, reset (sync, active-high), ce_1m (sample strobe),
//               voice1..3/ext_in (unsigned 12-bit), res_filt, mode_vol,
//               filt_out (signed 16) -> filt_in, audio_out (signed 16),
//               valid (result pulse), busy, overrun (sticky).
// Revision    : 1.0 - initial release
// ============================================================================
module sid_voice_mixer
    import sid_mix_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ce_1m,
    input  logic [VOICE_W-1:0]       voice1,
    input  logic [VOICE_W-1:0]       voice2,
    input  logic [VOICE_W-1:0]       voice3,
    input  logic [VOICE_W-1:0]       ext_in,
    input  logic [7:0]               res_filt,
    input  logic [7:0]               mode_vol,
    input  logic signed [ACC_W-1:0]  filt_out,
    output logic signed [ACC_W-1:0]  filt_in,
    output logic signed [ACC_W-1:0]  audio_out,
    output logic                     valid,
    output logic                     busy,
    output logic                     overrun
);

    mix_state_t                r_state;
    logic [VOICE_W-1:0]        r_v1, r_v2, r_v3;
    logic [3:0]                r_route;
    logic                      r_v3_off;
    logic [3:0]                r_vol;
    logic signed [ACC_W-1:0]   r_filt_out;
    logic signed [ACC_W-1:0]   r_dir_acc;
    logic signed [ACC_W-1:0]   r_flt_acc;

    logic [VOICE_W-1:0]        w_raw;
    logic                      w_route;
    logic                      w_mute;
    logic signed [SAMPLE_W-1:0] w_sample;
    logic signed [ACC_W-1:0]   w_acc_sel;
    logic signed [ACC_W-1:0]   w_add;
    logic signed [ACC_W:0]     w_sum;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_sat;

`ifdef SID_EXT_IN_EN
    logic [VOICE_W-1:0]        r_ext;
    wire                       w_unused_ok = ^{res_filt[7:4], mode_vol[6:4]};
`else
    wire                       w_unused_ok = ^{ext_in, res_filt[7:4], mode_vol[6:4], r_route[3]};
`endif

    // Source select for the shared adder, driven by the current step.
    always_comb begin
        w_raw   = r_v1;
        w_route = r_route[0];
        w_mute  = 1'b0;
        case (r_state)
            ST_V2: begin
                w_raw   = r_v2;
                w_route = r_route[1];
            end
            ST_V3: begin
                w_raw   = r_v3;
                w_route = r_route[2];
                // Voice-3 off only silences the direct path, never the filter path.
                w_mute  = r_v3_off & ~r_route[2];
            end
`ifdef SID_EXT_IN_EN
            ST_EXT: begin
                w_raw   = r_ext;
                w_route = r_route[3];
            end
`endif
            default: ;
        endcase
    end

    assign w_sample  = w_mute ? '0 : to_sample(w_raw);
    assign w_acc_sel = w_route ? r_flt_acc : r_dir_acc;
    assign w_add     = w_acc_sel + {{(ACC_W-SAMPLE_W){w_sample[SAMPLE_W-1]}}, w_sample};

    // Volume stage: 17-bit sum times zero-extended 4-bit volume fits in 21 bits.
    assign w_sum  = $signed({r_dir_acc[ACC_W-1], r_dir_acc}) + $signed({r_filt_out[ACC_W-1], r_filt_out});
    assign w_prod = $signed({{(PROD_W-ACC_W-1){w_sum[ACC_W]}}, w_sum}) * $signed({17'd0, r_vol});

    sid_mix_sat u_sat (
        .i_prod   (w_prod),
        .o_sample (w_sat)
    );

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_v1       <= '0;
            r_v2       <= '0;
            r_v3       <= '0;
`ifdef SID_EXT_IN_EN
            r_ext      <= '0;
`endif
            r_route    <= '0;
            r_v3_off   <= 1'b0;
            r_vol      <= '0;
            r_filt_out <= '0;
            r_dir_acc  <= '0;
            r_flt_acc  <= '0;
            filt_in    <= '0;
            audio_out  <= '0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (ce_1m && (r_state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (ce_1m) begin
                        r_v1       <= voice1;
                        r_v2       <= voice2;
                        r_v3       <= voice3;
`ifdef SID_EXT_IN_EN
                        r_ext      <= ext_in;
`endif
                        r_route    <= res_filt[3:0];
                        r_v3_off   <= mode_vol[7];
                        r_vol      <= mode_vol[3:0];
                        r_filt_out <= filt_out;
                        r_dir_acc  <= '0;
                        r_flt_acc  <= '0;
                        r_state    <= ST_V1;
                    end
                end
                ST_V1, ST_V2, ST_V3, ST_EXT: begin
                    if (w_route) begin
                        r_flt_acc <= w_add;
                    end else begin
                        r_dir_acc <= w_add;
                    end
                    case (r_state)
                        ST_V1:   r_state <= ST_V2;
                        ST_V2:   r_state <= ST_V3;
`ifdef SID_EXT_IN_EN
                        ST_V3:   r_state <= ST_EXT;
`else
                        ST_V3:   r_state <= ST_VOL;
`endif
                        default: r_state <= ST_VOL;
                    endcase
                end
                ST_VOL: begin
                    audio_out <= w_sat;
                    filt_in   <= r_flt_acc;
                    valid     <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sid_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sid_voice_mixer
// Description : Self-checking bench for sid_voice_mixer. Stimulus pushes the
//               expected frame result (from an integer reference model) into
//               a scoreboard; a forked monitor pops and compares on valid,
//               including the cycle at which valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sid_voice_mixer;

`ifdef SID_EXT_IN_EN
    localparam int LAT    = 6;
    localparam bit EXT_EN = 1'b1;
`else
    localparam int LAT    = 5;
    localparam bit EXT_EN = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset;
    logic               ce_1m;
    logic [11:0]        voice1, voice2, voice3, ext_in;
    logic [7:0]         res_filt, mode_vol;
    logic [15:0]        filt_out;
    logic [15:0]        filt_in, audio_out;
    logic               valid, busy, overrun;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int fi;
        int ao;
        int due;
    } exp_t;

    exp_t sb[$];

    sid_voice_mixer dut (
        .clock     (clock),
        .reset     (reset),
        .ce_1m     (ce_1m),
        .voice1    (voice1),
        .voice2    (voice2),
        .voice3    (voice3),
        .ext_in    (ext_in),
        .res_filt  (res_filt),
        .mode_vol  (mode_vol),
        .filt_out  (filt_out),
        .filt_in   (filt_in),
        .audio_out (audio_out),
        .valid     (valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: sum re-centred sources by destination, add last filter
    // output, scale by volume, divide by 16 rounding down, clamp.
    function automatic void model(input logic [11:0] a, b, c, e,
                                  input logic [7:0] rf, mv,
                                  input logic [15:0] fo,
                                  output int fi, output int ao);
        int s[4];
        int dir = 0;
        int flt = 0;
        int t;
        s[0] = int'(a) - 2048;
        s[1] = int'(b) - 2048;
        s[2] = int'(c) - 2048;
        s[3] = int'(e) - 2048;
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && !EXT_EN) continue;
            if (rf[i]) flt += s[i];
            else if (!(i == 2 && mv[7])) dir += s[i];
        end
        t  = (dir + int'($signed(fo))) * int'(mv[3:0]);
        ao = t >>> 4;
        if (ao > 32767)  ao = 32767;
        if (ao < -32768) ao = -32768;
        fi = flt;
    endfunction

    task automatic scramble();
        voice1   = 12'($urandom);
        voice2   = 12'($urandom);
        voice3   = 12'($urandom);
        ext_in   = 12'($urandom);
        res_filt = 8'($urandom);
        mode_vol = 8'($urandom);
        filt_out = 16'($urandom);
    endtask

    // Called at a negedge; drives a one-cycle ce_1m and returns one negedge later.
    task automatic issue(input logic [11:0] a, b, c, e, input logic [7:0] rf, mv,
                         input logic [15:0] fo, input bit expect_frame);
        exp_t x;
        voice1 = a; voice2 = b; voice3 = c; ext_in = e;
        res_filt = rf; mode_vol = mv; filt_out = fo;
        ce_1m = 1'b1;
        if (expect_frame) begin
            model(a, b, c, e, rf, mv, fo, x.fi, x.ao);
            x.due = cyc + LAT;
            sb.push_back(x);
        end
        @(negedge clock);
        ce_1m = 1'b0;
        scramble();
    endtask

    // Frame followed by `gap` idle cycles; gap 0 re-issues in the valid cycle.
    task automatic frame(input logic [11:0] a, b, c, e, input logic [7:0] rf, mv,
                         input logic [15:0] fo, input int gap);
        issue(a, b, c, e, rf, mv, fo, 1'b1);
        repeat (LAT - 1 + gap) @(negedge clock);
    endtask

    task automatic monitor();
        exp_t x;
        forever begin
            @(negedge clock);
            if (valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    x = sb.pop_front();
                    check("filt_in",   int'($signed(filt_in)),   x.fi);
                    check("audio_out", int'($signed(audio_out)), x.ao);
                    check("valid_cycle", cyc, x.due);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_filt_in"},   int'(filt_in),   0);
        check({tag, "_audio_out"}, int'(audio_out), 0);
        check({tag, "_valid"},     int'(valid),     0);
        check({tag, "_busy"},      int'(busy),      0);
        check({tag, "_overrun"},   int'(overrun),   0);
    endtask

    initial begin
        reset = 1'b1;
        ce_1m = 1'b0;
        voice1 = '0; voice2 = '0; voice3 = '0; ext_in = '0;
        res_filt = '0; mode_vol = '0; filt_out = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        // Directed frames
        frame(12'hFFF, 12'h800, 12'h000, 12'h800, 8'h00, 8'h0F, 16'd0,    1); // -> -1
        frame(12'hC00, 12'h800, 12'h800, 12'h800, 8'h01, 8'h08, 16'd1000, 0); // -> 1024 / 500
        frame(12'h800, 12'h800, 12'hFFF, 12'h800, 8'h00, 8'h8F, 16'd0,    0); // muted v3
        frame(12'h800, 12'h800, 12'hFFF, 12'h800, 8'h04, 8'h8F, 16'd0,    0); // filtered v3
        frame(12'h800, 12'h800, 12'hFFF, 12'h800, 8'h00, 8'h0F, 16'd0,    0); // v3 on
        frame(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 8'h00, 8'h0F, 16'h7FFF, 0); // +sat
        frame(12'h000, 12'h000, 12'h000, 12'h000, 8'h00, 8'h0F, 16'h8000, 0); // -sat
        frame(12'h800, 12'h800, 12'h800, 12'hFFF, 8'h08, 8'h0F, 16'd0,    0); // ext routed
        frame(12'h800, 12'h800, 12'h800, 12'h000, 8'hF0, 8'h7F, 16'd0,    2); // ext direct, high bits ignored
        frame(12'hABC, 12'h123, 12'h456, 12'h789, 8'h0A, 8'h00, 16'h1234, 1); // vol 0

        // busy visibility mid-frame
        issue(12'h900, 12'h700, 12'h800, 12'h800, 8'h02, 8'h05, 16'hFF00, 1'b1);
        check("busy_mid_frame", int'(busy), 1);
        repeat (LAT) @(negedge clock);
        check("busy_after_frame", int'(busy), 0);
        check("no_overrun_yet", int'(overrun), 0);

        // Randomized frames with random inter-frame gaps
        for (int i = 0; i < 60; i++) begin
            frame(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
                  8'($urandom), 8'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        end
        repeat (LAT + 2) @(negedge clock);
        check("no_overrun_back_to_back", int'(overrun), 0);

        // Overrun: ce_1m held for two consecutive clocks
        voice1 = 12'hE00; voice2 = 12'h900; voice3 = 12'h300; ext_in = 12'h800;
        res_filt = 8'h02; mode_vol = 8'h0C; filt_out = 16'd300;
        ce_1m = 1'b1;
        begin
            exp_t x;
            model(voice1, voice2, voice3, ext_in, res_filt, mode_vol, filt_out, x.fi, x.ao);
            x.due = cyc + LAT;
            sb.push_back(x);
        end
        @(negedge clock);
        scramble();
        @(negedge clock);
        ce_1m = 1'b0;
        repeat (LAT + 2) @(negedge clock);
        check("overrun_set", int'(overrun), 1);
        frame(12'h810, 12'h800, 12'h800, 12'h800, 8'h00, 8'h0F, 16'd0, 2);
        check("overrun_sticky", int'(overrun), 1);

        // Reset mid-frame (asserted for edge E3, with a coincident ce_1m)
        frame(12'hC00, 12'h800, 12'h800, 12'h800, 8'h01, 8'h08, 16'd1000, 2);
        issue(12'hFFF, 12'hFFF, 12'h800, 12'h800, 8'h01, 8'h0F, 16'd50, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        ce_1m = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        ce_1m = 1'b0;
        check_reset_outputs("midreset");
        repeat (LAT + 2) @(negedge clock);
        check("midreset_still_idle", int'(busy), 0);
        frame(12'h900, 12'h800, 12'h700, 12'h800, 8'h04, 8'h0F, 16'd16, 2);
        check("clean_frame_no_overrun", int'(overrun), 0);

        repeat (LAT + 3) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
